mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data single-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESP
  } state_e;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } requester_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-port memory.
// Data has priority, with a consecutive-grant limit that protects fetch from starving.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_valid,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [ADDRESS_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]    dm_wdata,
  output logic [DATA_WIDTH-1:0]    dm_rdata,
  output logic                     dm_valid,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     stallf,
  output logic                     stallm
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  state_e                   state_q, state_d;
  requester_e               winner_q, winner_d;
  logic                     we_q, we_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [STARVE_W-1:0]      starve_q, starve_d;
  logic                     mem_en_d, mem_we_d, if_valid_d, dm_valid_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic                     fetch_wins;

  assign stallf = if_req & ~if_valid;
  assign stallm = dm_req & ~dm_valid;

  assign fetch_wins = if_req & (~dm_req | (starve_q == STARVE_W'(STARVE_LIMIT)));

  // Next-state, grant and datapath selection
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    we_d        = we_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;

    if (!if_req) starve_d = '0;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_en_d = 1'b1;
          lat_d    = LAT_W'(MEM_LATENCY);
          if (fetch_wins) begin
            winner_d   = REQ_IF;
            we_d       = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end else begin
            winner_d    = REQ_DM;
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_req && (starve_q != STARVE_W'(STARVE_LIMIT)))
              starve_d = starve_q + STARVE_W'(1);
          end
          // A one-cycle read has its data in the strobe cycle, so it skips the wait
          if ((!fetch_wins && dm_we) || (MEM_LATENCY == 1)) state_d = RESP;
          else                                              state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(2)) state_d = RESP;
      end
      RESP: begin
        // Counter sits at 1 here: read data is on mem_rdata this cycle
        if (!we_q) begin
          if (winner_q == REQ_IF) if_rdata_d = mem_rdata;
          else                    dm_rdata_d = mem_rdata;
        end
        if (winner_q == REQ_IF) if_valid_d = 1'b1;
        else                    dm_valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      winner_q  <= REQ_IF;
      we_q      <= 1'b0;
      lat_q     <= '0;
      starve_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      we_q      <= we_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data reads, writes, starvation, reset abort, back-to-back.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stallf, stallm;
  logic [31:0] rd_q;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned dual_valid = 0;

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stallf(stallf), .stallm(stallm)
  );

  always #5 clk = ~clk;

  // Memory contents: one fixed instruction word, otherwise address-tagged pattern
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00A00513 : {a[15:0], 16'hC0DE};
  endfunction

  // Two-cycle read memory: data present in the cycle after the strobe, garbage otherwise
  always @(posedge clk) rd_q <= (mem_en && !mem_we) ? mem_fn(mem_addr) : 32'hBAD0BAD0;
  assign mem_rdata = rd_q;

  always @(negedge clk) if (if_valid && dm_valid) dual_valid++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] order;
    logic [47:0] exp_order;
    int          n_grant, nv_dm, nv_if, n_en;

    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) cyc();
    check_eq("rst_mem_en", 64'(mem_en), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_if_valid", 64'(if_valid), 64'd0);
    check_eq("rst_dm_valid", 64'(dm_valid), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_if_rdata", 64'(if_rdata), 64'd0);
    check_eq("rst_dm_rdata", 64'(dm_rdata), 64'd0);
    rst = 1'b1;
    cyc();

    // Single fetch read
    if_req = 1'b1; if_addr = 32'h10;
    #1 check_eq("f_stallf_c0", 64'(stallf), 64'd1);
    cyc();
    check_eq("f_mem_en_c1", 64'(mem_en), 64'd1);
    check_eq("f_mem_we_c1", 64'(mem_we), 64'd0);
    check_eq("f_mem_addr_c1", 64'(mem_addr), 64'h10);
    check_eq("f_stallf_c1", 64'(stallf), 64'd1);
    cyc();
    check_eq("f_mem_en_c2", 64'(mem_en), 64'd0);
    check_eq("f_if_valid_c2", 64'(if_valid), 64'd0);
    check_eq("f_stallf_c2", 64'(stallf), 64'd1);
    cyc();
    check_eq("f_if_valid_c3", 64'(if_valid), 64'd1);
    check_eq("f_if_rdata_c3", 64'(if_rdata), 64'h00A00513);
    check_eq("f_stallf_c3", 64'(stallf), 64'd0);
    if_req = 1'b0;
    cyc();
    check_eq("f_if_valid_c4", 64'(if_valid), 64'd0);
    check_eq("f_mem_en_c4", 64'(mem_en), 64'd0);

    // Simultaneous requests: data first, fetch right after dm_valid
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    cyc();
    check_eq("s_mem_addr_c1", 64'(mem_addr), 64'h100);
    cyc(); cyc();
    check_eq("s_dm_valid_c3", 64'(dm_valid), 64'd1);
    check_eq("s_if_valid_c3", 64'(if_valid), 64'd0);
    check_eq("s_dm_rdata_c3", 64'(dm_rdata), 64'h0100C0DE);
    dm_req = 1'b0;
    cyc();
    check_eq("s_mem_en_c4", 64'(mem_en), 64'd1);
    check_eq("s_mem_addr_c4", 64'(mem_addr), 64'h20);
    cyc(); cyc();
    check_eq("s_if_valid_c6", 64'(if_valid), 64'd1);
    check_eq("s_if_rdata_c6", 64'(if_rdata), 64'h0020C0DE);
    if_req = 1'b0;
    cyc();

    // Data write
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    cyc();
    check_eq("w_mem_en_c1", 64'(mem_en), 64'd1);
    check_eq("w_mem_we_c1", 64'(mem_we), 64'd1);
    check_eq("w_mem_addr_c1", 64'(mem_addr), 64'h200);
    check_eq("w_mem_wdata_c1", 64'(mem_wdata), 64'hDEADBEEF);
    check_eq("w_dm_valid_c1", 64'(dm_valid), 64'd0);
    cyc();
    check_eq("w_dm_valid_c2", 64'(dm_valid), 64'd1);
    check_eq("w_mem_we_c2", 64'(mem_we), 64'd0);
    check_eq("w_dm_rdata_hold", 64'(dm_rdata), 64'h0100C0DE);
    dm_req = 1'b0; dm_we = 1'b0;
    cyc();

    // Starvation: both held, grant order must be D,D,D,D,I,D
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    order = '0; n_grant = 0;
    exp_order = 48'h44_44_44_44_49_44;
    for (int c = 0; c < 40 && n_grant < 6; c++) begin
      cyc();
      if (mem_en) begin
        order = {order[39:0], (mem_addr == 32'h40) ? 8'h49 : 8'h44};
        n_grant++;
      end
    end
    check_eq("starve_order", 64'(order), 64'(exp_order));
    check_eq("starve_if_rdata", 64'(if_rdata), 64'h0040C0DE);
    // Requests dropped mid-access: the data read must still complete
    if_req = 1'b0; dm_req = 1'b0;
    nv_dm = 0; nv_if = 0; n_en = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      nv_dm += int'(dm_valid); nv_if += int'(if_valid); n_en += int'(mem_en);
    end
    check_eq("drop_dm_valid_cnt", 64'(nv_dm), 64'd1);
    check_eq("drop_if_valid_cnt", 64'(nv_if), 64'd0);
    check_eq("drop_mem_en_cnt", 64'(n_en), 64'd0);
    check_eq("drop_dm_rdata", 64'(dm_rdata), 64'h0300C0DE);

    // Reset in the middle of a fetch read
    if_req = 1'b1; if_addr = 32'h80;
    cyc();
    check_eq("r_mem_en_c1", 64'(mem_en), 64'd1);
    rst = 1'b0; if_req = 1'b0;
    #1;
    check_eq("r_mem_en_async", 64'(mem_en), 64'd0);
    check_eq("r_mem_addr_async", 64'(mem_addr), 64'd0);
    check_eq("r_if_rdata_async", 64'(if_rdata), 64'd0);
    check_eq("r_dm_rdata_async", 64'(dm_rdata), 64'd0);
    nv_if = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      nv_if += int'(if_valid);
    end
    rst = 1'b1; dm_req = 1'b1; dm_addr = 32'h104;
    cyc();
    nv_if += int'(if_valid);
    check_eq("r_mem_en_after", 64'(mem_en), 64'd1);
    check_eq("r_mem_addr_after", 64'(mem_addr), 64'h104);
    cyc();
    nv_if += int'(if_valid);
    cyc();
    nv_if += int'(if_valid);
    check_eq("r_dm_valid_after", 64'(dm_valid), 64'd1);
    check_eq("r_dm_rdata_after", 64'(dm_rdata), 64'h0104C0DE);
    check_eq("r_no_if_valid", 64'(nv_if), 64'd0);
    dm_req = 1'b0;
    cyc();

    // Back-to-back fetches with request held
    if_req = 1'b1; if_addr = 32'h0;
    cyc(); cyc(); cyc();
    check_eq("b_if_valid_1", 64'(if_valid), 64'd1);
    check_eq("b_if_rdata_1", 64'(if_rdata), 64'h0000C0DE);
    if_addr = 32'h4;
    cyc();
    check_eq("b_mem_en_2", 64'(mem_en), 64'd1);
    check_eq("b_mem_addr_2", 64'(mem_addr), 64'h4);
    cyc(); cyc();
    check_eq("b_if_valid_2", 64'(if_valid), 64'd1);
    check_eq("b_if_rdata_2", 64'(if_rdata), 64'h0004C0DE);
    if_req = 1'b0;
    cyc();
    check_eq("b_mem_en_idle", 64'(mem_en), 64'd0);

    check_eq("no_dual_valid", 64'(dual_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1);
  end

endmodule
